// File: rtl/paged_burst_mem_controller.sv
// rtl/paged_burst_mem_controller.sv - page-decoded burst memory controller on a multiplexed AddrData bus
// Serves 1/2/4/8-beat incrementing or wrapping bursts from its own word storage.
module paged_burst_mem_controller #(
    parameter int                DATA_W = 16,
    parameter int                PAGE_W = 4,
    parameter logic [PAGE_W-1:0] PAGE   = PAGE_W'(2),
    parameter int                MEM_AW = 8
) (
    input  logic              clk,
    input  logic              resetH,
    inout  wire  [DATA_W-1:0] AddrData,
    input  logic              AddrValid,
    input  logic              rw,
    output logic              DataValid,
    output logic              Busy
);
    generate
        if (PAGE_W + MEM_AW + 3 > DATA_W) begin : g_bad_params
            $error("paged_burst_mem_controller: PAGE_W + MEM_AW + 3 exceeds DATA_W");
        end
    endgenerate

    typedef enum logic {IDLE, XFER} state_t;

    state_t            state_q;
    logic [MEM_AW-1:0] addr_q;
    logic [MEM_AW-1:0] addr_d;
    logic [MEM_AW-1:0] addr_inc;
    logic [MEM_AW-1:0] mask_ext;
    logic [2:0]        mask_q;
    logic [2:0]        mask_d;
    logic [2:0]        cnt_q;
    logic              rw_q;
    logic              wrap_q;
    logic              busy_q;
    logic              dv_q;
    logic              page_hit;
    logic              drive;
    logic              unused_bits;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] mem [2**MEM_AW];

    // Length is held as len-1 so it doubles as the wrap mask and the initial beat count.
    always_comb begin
        mask_d = 3'd0;
        case (AddrData[MEM_AW+1:MEM_AW])
            2'd0:    mask_d = 3'd0;
            2'd1:    mask_d = 3'd1;
            2'd2:    mask_d = 3'd3;
            default: mask_d = 3'd7;
        endcase
    end

    assign page_hit    = (AddrData[DATA_W-1 -: PAGE_W] == PAGE);
    assign unused_bits = ^AddrData;
    assign mask_ext    = MEM_AW'(mask_q);
    assign addr_inc    = addr_q + MEM_AW'(1);
    assign addr_d      = wrap_q ? ((addr_q & ~mask_ext) | (addr_inc & mask_ext)) : addr_inc;

    always_ff @(posedge clk) begin
        if (resetH) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            busy_q  <= 1'b0;
            dv_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (AddrValid && page_hit) begin
                        state_q <= XFER;
                        addr_q  <= AddrData[MEM_AW-1:0];
                        rw_q    <= rw;
                        wrap_q  <= AddrData[MEM_AW+2];
                        mask_q  <= mask_d;
                        cnt_q   <= mask_d;
                        busy_q  <= 1'b1;
                        dv_q    <= rw;
                    end
                end
                XFER: begin
                    addr_q <= addr_d;
                    if (cnt_q == 3'd0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        dv_q    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetH && state_q == XFER && !rw_q) begin
            mem[addr_q] <= AddrData;
        end
    end

    // Bus drive and DataValid drop the moment resetH rises, not at the next edge.
    assign rd_data   = mem[addr_q];
    assign drive     = (state_q == XFER) && rw_q && !resetH;
    assign AddrData  = drive ? rd_data : {DATA_W{1'bz}};
    assign DataValid = dv_q & ~resetH;
    assign Busy      = busy_q;

endmodule

// File: doc/paged_burst_mem_controller.md
# paged_burst_mem_controller

Parametrised successor to the page-decoded memory controller. It sits on the CPU's multiplexed AddrData bus and owns one memory page. It contains its own word-addressed storage and serves read and write bursts. Burst length (1/2/4/8) and burst mode (incrementing or wrapping) are selected per transaction from fields of the address word; the earlier controller supported only fixed 4-beat incrementing bursts.

## Interface
- DATA_W, 16: width of AddrData and of each memory word.
- PAGE_W, 4: width of the page field, AddrData[DATA_W-1 -: PAGE_W].
- PAGE, 4'h2: page value this instance responds to (PAGE_W bits).
- MEM_AW, 8: word-address width; storage depth is 2**MEM_AW.
- Legality: PAGE_W + MEM_AW + 3 <= DATA_W; violation is an elaboration error.

- clk  input  1  clock; all state updates on posedge.
- resetH  input  1  synchronous, active-high reset.
- AddrData  inout  DATA_W  multiplexed address/data bus.
- AddrValid  input  1  high for one cycle with a valid address word on AddrData.
- rw  input  1  1 = read, 0 = write; sampled with AddrValid.
- DataValid  output  1  high in every cycle the controller drives read data.
- Busy  output  1  high while a burst is in progress.

## Operation
- Address word fields (defaults in brackets):
  - page = top PAGE_W bits [15:12].
  - bit MEM_AW+2 = wrap [10].
  - bits MEM_AW+1:MEM_AW = len code [9:8]; 0→1, 1→2, 2→4, 3→8 beats.
  - bits MEM_AW-1:0 = start word address [7:0].
  - All remaining bits are ignored.
- States:
  - IDLE: accepts AddrValid.
  - XFER: beat counter runs from len-1 down to 0.
- Transitions:
  - IDLE→XFER when AddrValid && page==PAGE. The edge captures start address, rw, len and wrap.
  - XFER→IDLE after the final beat.
  - Any state→IDLE on resetH.
- Page mismatch: the request is ignored. State stays IDLE, nothing is written, the bus is never driven.
- AddrValid while Busy is ignored. It is neither queued nor treated as an error.
- Address sequence:
  - Incrementing: next = (addr+1) mod 2**MEM_AW, so 0xFF→0x00.
  - Wrapping: next = (addr & ~(len-1)) | ((addr+1) & (len-1)), staying within the len-aligned block.
- Write beat: mem[addr] <= AddrData at the posedge ending the beat.
- Read beat: the controller drives AddrData = mem[addr] (asynchronous array read) and DataValid=1.
- Bus release: AddrData is Z whenever state is IDLE, the burst is a write, or resetH is high.
- Reset clears state, counter, Busy and DataValid. Storage contents are not reset.
- Storage is the block's own reg array; no external memory instance is used.

## Timing
- T0: address cycle with AddrValid=1. Its posedge moves state to XFER.
- Beat k occupies cycle T0+k, for k = 1..len.
- Read data is valid for the whole beat cycle. Latency from address cycle to first data is 1 cycle.
- Write data must be stable at the posedge ending its beat.
- Busy=1 during T1..Tlen and 0 in IDLE.
- The earliest next AddrValid is accepted at Tlen+1 (0 turnaround cycles).
- resetH high at any posedge puts the block in IDLE at that edge.
  - A write beat coinciding with that edge is not written.
  - Bus drive and DataValid go low combinationally while resetH is high.
- Outputs after reset: AddrData=Z, DataValid=0, Busy=0.

## Test plan
- Write/read, incrementing, len 4:
  - Stimulus: write to addr word 0x2210 with data A0,A1,A2,A3; then read 0x2210.
  - Required response: read returns A0..A3 in cycles T1..T4; DataValid high for exactly 4 cycles; Busy drops at T5.
- Wrapping, len 8:
  - Stimulus: write 0x00..0x07 to words 0x08..0x0F; then read with address word 0x270D (wrap=1, len code 3, addr 0x0D).
  - Required response: word order 0D,0E,0F,08,09,0A,0B,0C, i.e. data 05,06,07,00,01,02,03,04.
- Address-space wrap and len 1:
  - Stimulus: incrementing len-2 write at 0xFF with data 11, 22; then len-1 reads at 0xFF and at 0x00.
  - Required response: reads return 11 and 22; each len-1 read shows DataValid for one cycle.
- Page mismatch:
  - Stimulus: write burst on page 3 to a word previously set to 5A5A.
  - Required response: Busy stays 0, AddrData stays Z from the controller, later read returns 5A5A.
- AddrValid during a burst:
  - Stimulus: assert AddrValid with a read address during beat 2 of a write burst.
  - Required response: it is ignored; the write completes normally and no read beats follow.
- Reset mid-read:
  - Stimulus: assert resetH during beat 2 of a len-8 read.
  - Required response: same cycle, AddrData=Z and DataValid=0; after the edge Busy=0; a new request in the cycle after resetH deasserts is accepted and completes correctly.
